// File: rtl/cook_timer_if.sv
// Button and display bundle for the cook timer controller.
// master drives the buttons, slave is the controller side.
interface cook_timer_if;
    logic       btn_start;
    logic       btn_clear;
    logic       btn_inc_min;
    logic       btn_inc_sec;
    logic [3:0] min10;
    logic [3:0] min1;
    logic [3:0] sec10;
    logic [3:0] sec1;
    logic [1:0] state;
    logic       alarm;
    logic       sec_tick;

    modport master (
        output btn_start, btn_clear, btn_inc_min, btn_inc_sec,
        input  min10, min1, sec10, sec1, state, alarm, sec_tick
    );

    modport slave (
        input  btn_start, btn_clear, btn_inc_min, btn_inc_sec,
        output min10, min1, sec10, sec1, state, alarm, sec_tick
    );
endinterface

// File: rtl/cook_timer_ctrl.sv
// Kitchen countdown timer: MM:SS in BCD, start/pause/clear, alarm.
// Optional macro ALARM_TIMEOUT_EN: alarm clears after ALARM_SEC seconds.
module cook_timer_ctrl #(
    parameter int unsigned CLK_PER_USEC = 100,
    parameter int unsigned USEC_PER_SEC = 1000000,
    parameter int unsigned ALARM_SEC    = 10
) (
    input logic         clk,
    input logic         reset_p,
    cook_timer_if.slave bus
);

    localparam int unsigned TICKS = CLK_PER_USEC * USEC_PER_SEC;
    localparam int          PW    = (TICKS > 1) ? $clog2(TICKS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_ALARM = 2'd3
    } state_t;

    // A zero-length alarm timeout has no meaning; reject it at elaboration.
    if (ALARM_SEC == 0) begin : g_bad_alarm_sec
        $error("ALARM_SEC must be at least 1");
    end

    state_t          state_q, state_d;
    logic [15:0]     time_q, time_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            alarm_q, alarm_d;
    logic            tick_q, tick_d;
    logic            presc_run, tick_now, any_btn;
    logic            act_clr, act_start, act_min, act_sec;
`ifdef ALARM_TIMEOUT_EN
    localparam int   AW = $clog2(ALARM_SEC + 1);
    logic [AW-1:0]   acnt_q, acnt_d;
`endif

    // +1 on a 00..59 BCD field, wrapping without carry.
    function automatic logic [7:0] inc60(input logic [7:0] v);
        logic [3:0] hi, lo;
        hi = v[7:4];
        lo = v[3:0];
        if (lo == 4'd9) begin
            lo = 4'd0;
            hi = (hi == 4'd5) ? 4'd0 : hi + 4'd1;
        end else begin
            lo = lo + 4'd1;
        end
        return {hi, lo};
    endfunction

    // -1 s on MM:SS; only called with a non-zero time.
    function automatic logic [15:0] dec_time(input logic [15:0] t);
        logic [3:0] a, b, c, d;
        {a, b, c, d} = t;
        if (d != 4'd0) begin
            d = d - 4'd1;
        end else if (c != 4'd0) begin
            c = c - 4'd1;
            d = 4'd9;
        end else begin
            c = 4'd5;
            d = 4'd9;
            if (b != 4'd0) begin
                b = b - 4'd1;
            end else begin
                a = a - 4'd1;
                b = 4'd9;
            end
        end
        return {a, b, c, d};
    endfunction

    // Button priority: clear > start > inc_min > inc_sec, one-hot result.
    assign act_clr   = bus.btn_clear;
    assign act_start = bus.btn_start & ~bus.btn_clear;
    assign act_min   = bus.btn_inc_min & ~bus.btn_start & ~bus.btn_clear;
    assign act_sec   = bus.btn_inc_sec & ~bus.btn_inc_min
                     & ~bus.btn_start & ~bus.btn_clear;
    assign any_btn   = bus.btn_clear | bus.btn_start
                     | bus.btn_inc_min | bus.btn_inc_sec;

`ifdef ALARM_TIMEOUT_EN
    assign presc_run = (state_q == S_RUN) || (state_q == S_ALARM);
`else
    assign presc_run = (state_q == S_RUN);
`endif
    assign tick_now  = presc_run && (presc_q == PW'(TICKS - 1));

    // Next-state, time, prescaler and flag logic.
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
`ifdef ALARM_TIMEOUT_EN
        acnt_d  = acnt_q;
`endif
        if (presc_run) begin
            presc_d = tick_now ? '0 : presc_q + PW'(1);
        end
        unique case (state_q)
            S_IDLE: begin
                unique case (1'b1)
                    act_clr:   time_d = '0;
                    act_start: if (time_q != '0) state_d = S_RUN;
                    act_min:   time_d[15:8] = inc60(time_q[15:8]);
                    act_sec:   time_d[7:0]  = inc60(time_q[7:0]);
                    default: ;
                endcase
            end
            S_RUN: begin
                unique case (1'b1)
                    act_clr: begin
                        state_d = S_IDLE;
                        time_d  = '0;
                    end
                    act_start: state_d = S_PAUSE;
                    default: begin
                        if (tick_now && !any_btn) begin
                            time_d = dec_time(time_q);
                            tick_d = 1'b1;
                            if (time_q == 16'h0001) begin
                                state_d = S_ALARM;
`ifdef ALARM_TIMEOUT_EN
                                acnt_d  = '0;
`endif
                            end
                        end
                    end
                endcase
            end
            S_PAUSE: begin
                unique case (1'b1)
                    act_clr: begin
                        state_d = S_IDLE;
                        time_d  = '0;
                    end
                    act_start: state_d = S_RUN;
                    default: ;
                endcase
            end
            S_ALARM: begin
                if (any_btn) begin
                    state_d = S_IDLE;
                    time_d  = '0;
`ifdef ALARM_TIMEOUT_EN
                end else if (tick_now) begin
                    tick_d = 1'b1;
                    if (acnt_q == AW'(ALARM_SEC - 1)) begin
                        state_d = S_IDLE;
                        time_d  = '0;
                    end else begin
                        acnt_d = acnt_q + AW'(1);
                    end
`endif
                end
            end
            default: ;
        endcase
        if (state_d == S_IDLE) begin
            presc_d = '0;
        end
        if (state_d == S_RUN && state_q != S_RUN) begin
            presc_d = '0;
        end
        alarm_d = (state_d == S_ALARM);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q <= S_IDLE;
            time_q  <= '0;
            presc_q <= '0;
            alarm_q <= 1'b0;
            tick_q  <= 1'b0;
`ifdef ALARM_TIMEOUT_EN
            acnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            presc_q <= presc_d;
            alarm_q <= alarm_d;
            tick_q  <= tick_d;
`ifdef ALARM_TIMEOUT_EN
            acnt_q  <= acnt_d;
`endif
        end
    end

    assign bus.min10    = time_q[15:12];
    assign bus.min1     = time_q[11:8];
    assign bus.sec10    = time_q[7:4];
    assign bus.sec1     = time_q[3:0];
    assign bus.state    = state_q;
    assign bus.alarm    = alarm_q;
    assign bus.sec_tick = tick_q;

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Self-checking bench for cook_timer_ctrl at 20 clk per second.
// Reference model keeps remaining time as a plain seconds count.
module tb_cook_timer_ctrl;

    localparam int CPU  = 2;
    localparam int UPS  = 10;
    localparam int ASEC = 3;
    localparam int N    = CPU * UPS;
`ifdef ALARM_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_ALARM = 3;

    // button vector order: {clear, start, inc_min, inc_sec}
    localparam logic [3:0] B_NONE = 4'b0000;
    localparam logic [3:0] B_SEC  = 4'b0001;
    localparam logic [3:0] B_MIN  = 4'b0010;
    localparam logic [3:0] B_STA  = 4'b0100;
    localparam logic [3:0] B_CLR  = 4'b1000;

    logic clk = 1'b0;
    logic reset_p;
    cook_timer_if bus();

    cook_timer_ctrl #(
        .CLK_PER_USEC(CPU),
        .USEC_PER_SEC(UPS),
        .ALARM_SEC   (ASEC)
    ) dut (
        .clk    (clk),
        .reset_p(reset_p),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    int m_st, m_secs, m_cnt, m_acnt;
    bit m_tick;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %0d expected %0d",
                     tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st   = M_IDLE;
        m_secs = 0;
        m_cnt  = 0;
        m_acnt = 0;
        m_tick = 1'b0;
    endtask

    task automatic to_idle();
        m_st   = M_IDLE;
        m_secs = 0;
    endtask

    // One clock edge of the behavioural timer.
    task automatic model_edge(input logic [3:0] b);
        bit any, counting, tk;
        int prev, mm, ss;
        any      = (b != 4'b0000);
        counting = (m_st == M_RUN) || (TO && m_st == M_ALARM);
        tk       = counting && (m_cnt == N - 1);
        prev     = m_st;
        mm       = m_secs / 60;
        ss       = m_secs % 60;
        m_tick   = 1'b0;
        if (counting) m_cnt = tk ? 0 : m_cnt + 1;
        case (m_st)
            M_IDLE: begin
                if (b[3]) m_secs = 0;
                else if (b[2]) begin
                    if (m_secs != 0) m_st = M_RUN;
                end
                else if (b[1]) m_secs = ((mm + 1) % 60) * 60 + ss;
                else if (b[0]) m_secs = mm * 60 + (ss + 1) % 60;
            end
            M_RUN: begin
                if (b[3]) to_idle();
                else if (b[2]) m_st = M_PAUSE;
                else if (tk && !any) begin
                    m_secs = m_secs - 1;
                    m_tick = 1'b1;
                    if (m_secs == 0) begin
                        m_st   = M_ALARM;
                        m_acnt = 0;
                    end
                end
            end
            M_PAUSE: begin
                if (b[3]) to_idle();
                else if (b[2]) m_st = M_RUN;
            end
            default: begin
                if (any) to_idle();
                else if (tk) begin
                    m_tick = 1'b1;
                    m_acnt = m_acnt + 1;
                    if (m_acnt == ASEC) to_idle();
                end
            end
        endcase
        if (m_st == M_IDLE) m_cnt = 0;
        if (m_st == M_RUN && prev != M_RUN) m_cnt = 0;
    endtask

    task automatic compare_all();
        chk("min10", 32'(bus.min10), 32'((m_secs / 60) / 10));
        chk("min1",  32'(bus.min1),  32'((m_secs / 60) % 10));
        chk("sec10", 32'(bus.sec10), 32'((m_secs % 60) / 10));
        chk("sec1",  32'(bus.sec1),  32'((m_secs % 60) % 10));
        chk("state", 32'(bus.state), 32'(m_st));
        chk("alarm", 32'(bus.alarm), 32'(m_st == M_ALARM));
        chk("sec_tick", 32'(bus.sec_tick), 32'(m_tick));
    endtask

    task automatic drive(input logic [3:0] b);
        bus.btn_clear   = b[3];
        bus.btn_start   = b[2];
        bus.btn_inc_min = b[1];
        bus.btn_inc_sec = b[0];
    endtask

    // Called at posedge+1; buttons are sampled at the next posedge.
    task automatic cyc(input logic [3:0] b);
        drive(b);
        @(posedge clk);
        model_edge(b);
        #1;
        drive(B_NONE);
        compare_all();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(B_NONE);
    endtask

    task automatic press(input logic [3:0] b, input int n);
        repeat (n) cyc(b);
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic do_reset();
        reset_p = 1'b1;
        #2;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        reset_p = 1'b0;
        compare_all();
    endtask

    initial begin
        int r;
        reset_p = 1'b1;
        drive(B_NONE);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        compare_all();
        reset_p = 1'b0;

        press(B_SEC, 3);
        press(B_MIN, 1);
        chk("set_0103", {bus.min10, bus.min1, bus.sec10, bus.sec1}, 32'h0103);

        cyc(B_CLR);
        press(B_SEC, 2);
        cyc(B_STA);
        idle(40);
        chk("countdown_alarm", 32'(bus.alarm), 32'd1);
        cyc(B_CLR);

        cyc(B_MIN);
        cyc(B_STA);
        idle(20);
        cyc(B_STA);
        idle(100);
        cyc(B_STA);
        idle(20);
        chk("resume_0058", {bus.min10, bus.min1, bus.sec10, bus.sec1}, 32'h0058);
        cyc(B_CLR);

        press(B_MIN, 59);
        press(B_SEC, 59);
        cyc(B_SEC);
        cyc(B_CLR);
        cyc(B_STA);
        chk("start_at_zero", 32'(bus.state), 32'd0);

        press(B_SEC, 5);
        cyc(B_STA);
        idle(7);
        cyc(B_CLR | B_STA);
        press(B_SEC, 5);
        cyc(B_STA);
        idle(25);
        do_reset();

        press(B_SEC, 1);
        cyc(B_STA);
        idle(20);
        idle(200);
        cyc(B_CLR);

        press(B_SEC, 2);
        cyc(B_STA);
        idle(19);
        cyc(B_SEC);
        idle(25);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 999);
            if (r == 0) begin
                do_reset();
            end else if (r < 30) begin
                cyc(4'($urandom_range(0, 15)));
            end else if (r < 100) begin
                cyc(B_SEC);
            end else if (r < 115) begin
                cyc(B_MIN);
            end else if (r < 135) begin
                cyc(B_STA);
            end else if (r < 140) begin
                cyc(B_CLR);
            end else begin
                cyc(B_NONE);
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/cook_timer_ctrl.md
COOK_TIMER_CTRL -- requirements
Module: cook_timer_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_PER_USEC, default 100, meaning clk cycles per 1 us tick.
REQ-002 The block SHALL have parameter USEC_PER_SEC, default 1000000, meaning 1 us ticks per 1 s tick (reduced in simulation).
REQ-003 The block SHALL have parameter ALARM_SEC, default 10, meaning alarm auto-clear duration in seconds (used only under the Configuration macro).
REQ-004 clk  input  1  system clock.
REQ-005 reset_p  input  1  reset, asynchronous, active-high.
REQ-006 btn_start  input  1  one-cycle pulse: start/pause toggle.
REQ-007 btn_clear  input  1  one-cycle pulse: cancel/clear.
REQ-008 btn_inc_min  input  1  one-cycle pulse: minutes +1 while setting.
REQ-009 btn_inc_sec  input  1  one-cycle pulse: seconds +1 while setting.
REQ-010 min10, min1, sec10, sec1  output  4 each  BCD remaining time MM:SS.
REQ-011 state  output  2  IDLE=0, RUN=1, PAUSE=2, ALARM=3.
REQ-012 alarm  output  1  high while in ALARM.
REQ-013 sec_tick  output  1  one-cycle pulse on each internal 1 s tick.

Function
REQ-014 The block SHALL generate sec_tick with an internal prescaler of CLK_PER_USEC x USEC_PER_SEC clk cycles that counts only in RUN (and ALARM under ALARM_TIMEOUT_EN) and is cleared on every entry to RUN.
REQ-015 The first decrement after entering RUN SHALL occur exactly CLK_PER_USEC x USEC_PER_SEC cycles after the sampling edge of btn_start.
REQ-016 Button priority when several pulses coincide SHALL be btn_clear > btn_start > btn_inc_min > btn_inc_sec; only the highest is acted on.
REQ-017 IDLE: btn_inc_sec SHALL increment seconds 00..59, wrapping 59->00 without carry into minutes; btn_inc_min likewise for minutes 00..59.
REQ-018 IDLE: btn_start with time != 00:00 SHALL move to RUN; with time == 00:00 SHALL be ignored.
REQ-019 IDLE: btn_clear SHALL set time to 00:00 and remain in IDLE.
REQ-020 RUN: each sec_tick SHALL decrement time by 1 s in BCD (x0 -> (x-1)9, S10=0,S1=0 -> borrow: minutes -1, seconds 59).
REQ-021 RUN: the decrement reaching 00:00 SHALL move to ALARM on the same edge; time never underflows below 00:00.
REQ-022 RUN: btn_start SHALL move to PAUSE holding time; btn_clear SHALL move to IDLE with time 00:00; inc buttons SHALL be ignored.
REQ-023 PAUSE: prescaler and time SHALL be frozen; btn_start SHALL return to RUN; btn_clear SHALL move to IDLE with time 00:00; inc buttons ignored.
REQ-024 ALARM: any button pulse SHALL move to IDLE with time 00:00 and alarm low.
REQ-025 All outputs SHALL be registered; state/time/alarm SHALL update on the clk edge that samples the button pulse or tick (one-cycle latency).
REQ-026 sec_tick and a button in the same cycle: the button action SHALL take precedence and the tick SHALL be discarded.

Reset
REQ-027 reset_p SHALL asynchronously force state=IDLE, time 00:00, alarm=0, sec_tick=0, prescaler and alarm counter to 0, at any time including mid-RUN or ALARM.

Configuration
REQ-028 With macro ALARM_TIMEOUT_EN defined, ALARM SHALL auto-return to IDLE (time 00:00, alarm=0) after ALARM_SEC sec_ticks counted from ALARM entry; without it, ALARM SHALL persist until a button pulse or reset.

Verification (CLK_PER_USEC=2, USEC_PER_SEC=10, i.e. 20 clk/s)
REQ-029 Reset, 3x btn_inc_sec, 1x btn_inc_min -> time 01:03, state IDLE, alarm 0.
REQ-030 Set 00:02, btn_start -> state RUN, time 00:01 after 20 clk, 00:00 and state ALARM/alarm=1 after 40 clk.
REQ-031 Set 01:00, start, 20 clk -> 00:59; btn_start -> PAUSE, 100 clk idle -> still 00:59; btn_start -> 00:58 exactly 20 clk later.
REQ-032 IDLE 59:59 + btn_inc_sec -> 59:00; btn_start at 00:00 -> state remains IDLE.
REQ-033 Same-cycle btn_clear + btn_start in RUN -> IDLE, 00:00; reset_p pulse mid-RUN -> IDLE, 00:00, sec_tick 0.
REQ-034 ALARM with ALARM_TIMEOUT_EN, ALARM_SEC=3 -> IDLE after 60 clk; without macro -> alarm still 1 after 200 clk until btn_clear.
